// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM stage encoding
// and helpers that locate the fields of a command word {cop, a1, a2, lit}.
package cpu_mc_pkg;

   localparam int OP_INCR = 0;
   localparam int OP_LTR  = 1;
   localparam int OP_NTR  = 2;
   localparam int OP_LTM  = 3;
   localparam int OP_SUB  = 4;
   localparam int OP_JLZ  = 5;
   localparam int OP_PTR  = 6;
   localparam int OP_SWP  = 7;
   localparam int OP_JMP  = 8;
   localparam int OP_HLT  = 9;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_F    = 3'd1,
      ST_D    = 3'd2,
      ST_E    = 3'd3,
      ST_M    = 3'd4,
      ST_W    = 3'd5
   } state_t;

   // Total command word width.
   function automatic int cmd_width(input int cop_w, input int gpr_aw, input int data_w);
      return cop_w + 2 * gpr_aw + data_w;
   endfunction

   // LSB of the a2 field (the literal occupies the low data_w bits).
   function automatic int a2_lsb(input int data_w);
      return data_w;
   endfunction

   // LSB of the a1 field.
   function automatic int a1_lsb(input int data_w, input int gpr_aw);
      return data_w + gpr_aw;
   endfunction

   // LSB of the opcode field.
   function automatic int cop_lsb(input int data_w, input int gpr_aw);
      return data_w + 2 * gpr_aw;
   endfunction

   // Opcodes 0..HLT are defined; everything above traps.
   function automatic logic is_legal(input int op);
      return (op >= 0) && (op <= OP_HLT);
   endfunction

   // Opcodes whose result is written back to R[a1] in W.
   function automatic logic writes_gpr(input int op);
      return (op == OP_INCR) || (op == OP_LTR) || (op == OP_NTR) ||
             (op == OP_SUB)  || (op == OP_PTR);
   endfunction

endpackage

// File: rtl/cpu_mc_core_gpr_file.sv
// General-purpose register file: two asynchronous operand reads, one
// asynchronous debug read and a single synchronous write port.
// Asynchronous reset clears every register.
module gpr_file
   import cpu_mc_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int GPR_FILE_SIZE = 8,
   parameter int GPR_AW        = 3
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_we,
   input  logic [GPR_AW-1:0]     i_wa,
   input  logic [DATA_WIDTH-1:0] i_wd,
   input  logic [GPR_AW-1:0]     i_ra1,
   input  logic [GPR_AW-1:0]     i_ra2,
   input  logic [GPR_AW-1:0]     i_dbg_addr,
   output logic [DATA_WIDTH-1:0] o_rd1,
   output logic [DATA_WIDTH-1:0] o_rd2,
   output logic [DATA_WIDTH-1:0] o_dbg_data
);

   logic [DATA_WIDTH-1:0] r_regs [GPR_FILE_SIZE];

   // Register storage: cleared on reset, single write per cycle otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < GPR_FILE_SIZE; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   assign o_rd1      = r_regs[i_ra1];
   assign o_rd2      = r_regs[i_ra2];
   assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/cpu_mc_core.sv
// Parametrised multi-cycle processor core. Each instruction walks
// F -> D -> E -> M -> W (5 cycles); HLT and illegal opcodes return to IDLE.
// Owns the command memory, the data memory and the GPR file.
module cpu_mc_core
   import cpu_mc_pkg::*;
#(
   parameter int    DATA_WIDTH     = 32,
   parameter int    GPR_FILE_SIZE  = 8,
   parameter int    CMD_ADDR_WIDTH = 6,
   parameter int    MEM_ADDR_WIDTH = 6,
   parameter int    COP_WIDTH      = 4,
   parameter string INIT_FILE      = "",
   localparam int   GPR_AW         = $clog2(GPR_FILE_SIZE),
   localparam int   CMD_WIDTH      = cmd_width(COP_WIDTH, GPR_AW, DATA_WIDTH)
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      prog_we,
   input  logic [CMD_ADDR_WIDTH-1:0] prog_addr,
   input  logic [CMD_WIDTH-1:0]      prog_data,
   input  logic [GPR_AW-1:0]         dbg_addr,
   output logic [DATA_WIDTH-1:0]     dbg_data,
   output logic                      halted,
   output logic                      err,
   output logic [CMD_ADDR_WIDTH-1:0] pc,
   output logic [31:0]               retired
);

   localparam int CMD_DEPTH = 2 ** CMD_ADDR_WIDTH;
   localparam int MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
   localparam int COP_LSB   = cop_lsb(DATA_WIDTH, GPR_AW);
   localparam int A1_LSB    = a1_lsb(DATA_WIDTH, GPR_AW);
   localparam int A2_LSB    = a2_lsb(DATA_WIDTH);

   logic [CMD_WIDTH-1:0]  r_cmd  [CMD_DEPTH];
   logic [DATA_WIDTH-1:0] r_dmem [MEM_DEPTH];

   state_t                      r_state;
   state_t                      w_next;
   logic [CMD_ADDR_WIDTH-1:0]   r_pc;
   logic [CMD_WIDTH-1:0]        r_pr;
   logic [DATA_WIDTH-1:0]       r_alu1;
   logic [DATA_WIDTH-1:0]       r_alu2;
   logic [DATA_WIDTH-1:0]       r_res;
   logic                        r_lz;
   logic [31:0]                 r_retired;
   logic                        r_err;

   logic [COP_WIDTH-1:0]        w_cop;
   int                          w_op;
   logic [GPR_AW-1:0]           w_a1;
   logic [GPR_AW-1:0]           w_a2;
   logic [DATA_WIDTH-1:0]       w_lit;
   logic [CMD_ADDR_WIDTH-1:0]   w_target;
   logic [CMD_ADDR_WIDTH-1:0]   w_pc_inc;
   logic [MEM_ADDR_WIDTH-1:0]   w_ad1;
   logic [MEM_ADDR_WIDTH-1:0]   w_ad2;
   logic [DATA_WIDTH-1:0]       w_rd1;
   logic [DATA_WIDTH-1:0]       w_rd2;
   logic                        w_legal;
   logic                        w_gpr_we;
   logic signed [DATA_WIDTH:0]  w_diff;

   // Instruction fields decoded from the fetched word.
   assign w_cop    = r_pr[COP_LSB +: COP_WIDTH];
   assign w_op     = int'(w_cop);
   assign w_a1     = r_pr[A1_LSB +: GPR_AW];
   assign w_a2     = r_pr[A2_LSB +: GPR_AW];
   assign w_lit    = r_pr[DATA_WIDTH-1:0];
   assign w_target = w_lit[CMD_ADDR_WIDTH-1:0];
   assign w_pc_inc = r_pc + 1'b1;
   assign w_ad1    = r_alu1[MEM_ADDR_WIDTH-1:0];
   assign w_ad2    = r_alu2[MEM_ADDR_WIDTH-1:0];
   assign w_legal  = is_legal(w_op);

   // Sign-extended difference: its MSB is the signed less-than result.
   assign w_diff = $signed({r_alu1[DATA_WIDTH-1], r_alu1}) -
                   $signed({r_alu2[DATA_WIDTH-1], r_alu2});

   gpr_file #(
      .DATA_WIDTH    (DATA_WIDTH),
      .GPR_FILE_SIZE (GPR_FILE_SIZE),
      .GPR_AW        (GPR_AW)
   ) u_gpr (
      .clk        (clk),
      .reset      (reset),
      .i_we       (w_gpr_we),
      .i_wa       (w_a1),
      .i_wd       (r_res),
      .i_ra1      (w_a1),
      .i_ra2      (w_a2),
      .i_dbg_addr (dbg_addr),
      .o_rd1      (w_rd1),
      .o_rd2      (w_rd2),
      .o_dbg_data (dbg_data)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state sequencing and the W-stage register write enable.
   always_comb begin
      w_next   = r_state;
      w_gpr_we = 1'b0;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_F;
         ST_F:    w_next = ST_D;
         ST_D:    w_next = ST_E;
         ST_E:    w_next = w_legal ? ST_M : ST_IDLE;
         ST_M:    w_next = ST_W;
         ST_W: begin
            w_gpr_we = writes_gpr(w_op);
            w_next   = (w_op == OP_HLT) ? ST_IDLE : ST_F;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Per-stage datapath registers: fetch, operand latch, execute, PTR load, retire.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc      <= '0;
         r_pr      <= '0;
         r_alu1    <= '0;
         r_alu2    <= '0;
         r_res     <= '0;
         r_lz      <= 1'b0;
         r_retired <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (start) r_err <= 1'b0;
            ST_F: r_pr <= r_cmd[r_pc];
            ST_D: begin
               r_alu1 <= w_rd1;
               r_alu2 <= w_rd2;
            end
            ST_E: begin
               if (!w_legal) begin
                  r_err <= 1'b1;
               end else begin
                  case (w_op)
                     OP_INCR: r_res <= r_alu1 + 1'b1;
                     OP_LTR:  r_res <= w_lit;
                     OP_NTR:  r_res <= r_alu2;
                     OP_SUB: begin
                        r_res <= w_diff[DATA_WIDTH-1:0];
                        r_lz  <= w_diff[DATA_WIDTH];
                     end
                     default: ;
                  endcase
               end
            end
            ST_M: if (w_op == OP_PTR) r_res <= r_dmem[w_ad2];
            ST_W: begin
               r_retired <= r_retired + 32'd1;
               case (w_op)
                  OP_JLZ:  r_pc <= r_lz ? w_target : w_pc_inc;
                  OP_JMP:  r_pc <= w_target;
                  OP_HLT:  r_pc <= r_pc;
                  default: r_pc <= w_pc_inc;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Host program load; only accepted while the core is idle.
   always_ff @(posedge clk) begin
      if ((r_state == ST_IDLE) && prog_we) r_cmd[prog_addr] <= prog_data;
   end

   // Data memory writes happen only in M; a self-swap leaves memory unchanged.
   always_ff @(posedge clk) begin
      if (r_state == ST_M) begin
         if (w_op == OP_LTM) begin
            r_dmem[w_ad1] <= w_lit;
         end else if ((w_op == OP_SWP) && (w_ad1 != w_ad2)) begin
            r_dmem[w_ad1] <= r_dmem[w_ad2];
            r_dmem[w_ad2] <= r_dmem[w_ad1];
         end
      end
   end

   assign halted  = (r_state == ST_IDLE);
   assign err     = r_err;
   assign pc      = r_pc;
   assign retired = r_retired;

endmodule

// File: tb/tb_cpu_mc_core.sv
// Bench for cpu_mc_core: directed programs plus random programs checked
// against an instruction-level interpreter of the processor's ISA.
module tb_cpu_mc_core;

   localparam logic [3:0] I_INCR = 4'd0;
   localparam logic [3:0] I_LTR  = 4'd1;
   localparam logic [3:0] I_NTR  = 4'd2;
   localparam logic [3:0] I_LTM  = 4'd3;
   localparam logic [3:0] I_SUB  = 4'd4;
   localparam logic [3:0] I_JLZ  = 4'd5;
   localparam logic [3:0] I_PTR  = 4'd6;
   localparam logic [3:0] I_SWP  = 4'd7;
   localparam logic [3:0] I_JMP  = 4'd8;
   localparam logic [3:0] I_HLT  = 4'd9;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [41:0] prog_data;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        halted;
   logic        err;
   logic [5:0]  pc;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;

   // Reference machine state
   logic [41:0] m_cmd [64];
   logic [31:0] m_mem [64];
   logic [31:0] m_gpr [8];
   logic [5:0]  m_pc;
   logic        m_lz;
   logic        m_err;
   logic [31:0] m_ret;

   always #5 clk = ~clk;

   cpu_mc_core #(
      .DATA_WIDTH     (32),
      .GPR_FILE_SIZE  (8),
      .CMD_ADDR_WIDTH (6),
      .MEM_ADDR_WIDTH (6),
      .COP_WIDTH      (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .halted    (halted),
      .err       (err),
      .pc        (pc),
      .retired   (retired)
   );

   function automatic logic [41:0] enc(input logic [3:0] op, input logic [2:0] a1,
                                       input logic [2:0] a2, input logic [31:0] lit);
      return {op, a1, a2, lit};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_gpr(input string tag, input int r, input logic [31:0] exp);
      dbg_addr = 3'(r);
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_gpr[i] = '0;
      m_pc  = '0;
      m_lz  = 1'b0;
      m_err = 1'b0;
      m_ret = '0;
   endtask

   // Execute instructions until HLT or an illegal opcode; report cycle cost.
   task automatic model_run(output int cyc);
      logic [41:0] w;
      logic [3:0]  op;
      logic [2:0]  a1, a2;
      logic [31:0] lit, v1, v2, t;
      logic [5:0]  ad1, ad2, np;
      bit          done;
      done  = 0;
      cyc   = 0;
      m_err = 1'b0;
      for (int g = 0; g < 2000 && !done; g++) begin
         w   = m_cmd[m_pc];
         op  = w[41:38];
         a1  = w[37:35];
         a2  = w[34:32];
         lit = w[31:0];
         v1  = m_gpr[a1];
         v2  = m_gpr[a2];
         ad1 = v1[5:0];
         ad2 = v2[5:0];
         if (op > I_HLT) begin
            m_err = 1'b1;
            cyc  += 3;
            done  = 1;
         end else begin
            cyc  += 5;
            m_ret = m_ret + 32'd1;
            np    = m_pc + 6'd1;
            case (op)
               I_INCR: m_gpr[a1] = v1 + 32'd1;
               I_LTR:  m_gpr[a1] = lit;
               I_NTR:  m_gpr[a1] = v2;
               I_LTM:  m_mem[ad1] = lit;
               I_SUB: begin
                  m_lz      = ($signed(v1) < $signed(v2));
                  m_gpr[a1] = v1 - v2;
               end
               I_JLZ:  if (m_lz) np = lit[5:0];
               I_PTR:  m_gpr[a1] = m_mem[ad2];
               I_SWP: begin
                  t          = m_mem[ad1];
                  m_mem[ad1] = m_mem[ad2];
                  m_mem[ad2] = t;
               end
               I_JMP:  np = lit[5:0];
               default: begin
                  np   = m_pc;
                  done = 1;
               end
            endcase
            m_pc = np;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic load(input logic [5:0] a, input logic [41:0] w);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = w;
      m_cmd[a]  = w;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
      chk({tag, ".retired"}, retired, m_ret);
      chk({tag, ".err"}, 32'(err), 32'(m_err));
      chk({tag, ".halted"}, 32'(halted), 32'd1);
      for (int r = 0; r < 8; r++) chk_gpr($sformatf("%s.r%0d", tag, r), r, m_gpr[r]);
   endtask

   // mode 0: plain start; 1: program write in the same cycle as start;
   // 2: program write attempted while running (must be ignored).
   task automatic run_and_check(input string tag, input int mode,
                                input logic [5:0] wa, input logic [41:0] wd,
                                output int n);
      int  exp_cyc;
      bit  seen;
      if (mode == 1) m_cmd[wa] = wd;
      model_run(exp_cyc);
      @(negedge clk);
      start = 1'b1;
      if (mode == 1) begin
         prog_we   = 1'b1;
         prog_addr = wa;
         prog_data = wd;
      end
      @(negedge clk);
      start   = 1'b0;
      prog_we = 1'b0;
      n    = 0;
      seen = 0;
      while (!seen && n < exp_cyc + 20) begin
         @(posedge clk);
         #1;
         n++;
         if (mode == 2 && n == 2) begin
            prog_we   = 1'b1;
            prog_addr = wa;
            prog_data = wd;
         end else begin
            prog_we = 1'b0;
         end
         if (halted) seen = 1;
      end
      prog_we = 1'b0;
      chk({tag, ".cycles"}, 32'(n), 32'(exp_cyc));
      check_state(tag);
   endtask

   initial begin
      int          n;
      int          len, tgt, p;
      logic [3:0]  op;
      logic [31:0] lit;

      reset     = 1'b1;
      start     = 1'b0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      dbg_addr  = '0;
      for (int i = 0; i < 64; i++) begin
         m_cmd[i] = '0;
         m_mem[i] = '0;
      end
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;

      // Reset state
      chk("rst.halted", 32'(halted), 32'd1);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.pc", 32'(pc), 32'd0);
      chk("rst.retired", retired, 32'd0);
      chk_gpr("rst.r2", 2, 32'd0);

      // LTR / INCR / HLT
      load(6'd0, enc(I_LTR, 3'd2, 3'd0, 32'd5));
      load(6'd1, enc(I_INCR, 3'd2, 3'd0, 32'd0));
      load(6'd2, enc(I_HLT, 3'd0, 3'd0, 32'd0));
      run_and_check("t1", 0, 6'd0, '0, n);
      chk("t1.n15", 32'(n), 32'd15);
      chk_gpr("t1.r2is6", 2, 32'd6);
      chk("t1.ret3", retired, 32'd3);
      chk("t1.pc2", 32'(pc), 32'd2);

      // Illegal opcode at address 0
      do_reset();
      load(6'd0, enc(4'hF, 3'd1, 3'd2, 32'h123));
      run_and_check("t4", 0, 6'd0, '0, n);
      chk("t4.n3", 32'(n), 32'd3);
      chk("t4.err1", 32'(err), 32'd1);
      chk("t4.ret0", retired, 32'd0);

      // SUB sets lz, JLZ taken / not taken
      do_reset();
      load(6'd0, enc(I_LTR, 3'd1, 3'd0, 32'd3));
      load(6'd1, enc(I_LTR, 3'd2, 3'd0, 32'd5));
      load(6'd2, enc(I_SUB, 3'd1, 3'd2, 32'd0));
      load(6'd3, enc(I_JLZ, 3'd0, 3'd0, 32'd10));
      load(6'd4, enc(I_HLT, 3'd0, 3'd0, 32'd0));
      load(6'd10, enc(I_HLT, 3'd0, 3'd0, 32'd0));
      run_and_check("t2a", 0, 6'd0, '0, n);
      chk_gpr("t2a.r1neg", 1, 32'hFFFF_FFFE);
      chk("t2a.pc10", 32'(pc), 32'd10);
      do_reset();
      load(6'd0, enc(I_LTR, 3'd1, 3'd0, 32'd7));
      run_and_check("t2b", 0, 6'd0, '0, n);
      chk_gpr("t2b.r1is2", 1, 32'd2);
      chk("t2b.pc4", 32'(pc), 32'd4);

      // Memory store, swap and load-back
      do_reset();
      load(6'd0, enc(I_LTR, 3'd3, 3'd0, 32'd4));
      load(6'd1, enc(I_LTR, 3'd4, 3'd0, 32'd9));
      load(6'd2, enc(I_LTM, 3'd3, 3'd0, 32'hAA));
      load(6'd3, enc(I_LTM, 3'd4, 3'd0, 32'hBB));
      load(6'd4, enc(I_SWP, 3'd3, 3'd4, 32'd0));
      load(6'd5, enc(I_PTR, 3'd5, 3'd3, 32'd0));
      load(6'd6, enc(I_PTR, 3'd6, 3'd4, 32'd0));
      load(6'd7, enc(I_HLT, 3'd0, 3'd0, 32'd0));
      run_and_check("t3", 0, 6'd0, '0, n);
      chk_gpr("t3.r5", 5, 32'hBB);
      chk_gpr("t3.r6", 6, 32'hAA);

      // Program write coinciding with start: fetch sees the new word
      load(6'd8, enc(I_HLT, 3'd0, 3'd0, 32'd0));
      run_and_check("tws", 1, 6'd7, enc(I_INCR, 3'd5, 3'd0, 32'd0), n);
      chk_gpr("tws.r5", 5, 32'hBC);

      // Fill all data memory with known random words
      for (int b = 0; b < 4; b++) begin
         do_reset();
         load(6'd0, enc(I_LTR, 3'd0, 3'd0, 32'(16 * b)));
         for (int j = 0; j < 16; j++) begin
            load(6'(2 * j + 1), enc(I_LTM, 3'd0, 3'd0, $urandom));
            load(6'(2 * j + 2), enc(I_INCR, 3'd0, 3'd0, 32'd0));
         end
         load(6'd33, enc(I_HLT, 3'd0, 3'd0, 32'd0));
         run_and_check($sformatf("init%0d", b), 0, 6'd0, '0, n);
      end

      // Random forward-jumping programs, some containing an illegal opcode
      for (int k = 0; k < 10; k++) begin
         do_reset();
         len = int'($urandom_range(6, 20));
         p   = (k % 3 == 2) ? int'($urandom_range(0, len - 1)) : -1;
         for (int i = 0; i < len; i++) begin
            op  = 4'($urandom_range(0, 8));
            lit = $urandom;
            if (op == I_JLZ || op == I_JMP) begin
               tgt = int'($urandom_range(i + 1, len));
               lit = {lit[31:6], tgt[5:0]};
            end
            if (i == p) op = 4'($urandom_range(10, 15));
            load(6'(i), enc(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), lit));
         end
         load(6'(len), enc(I_HLT, 3'd0, 3'd0, 32'd0));
         run_and_check($sformatf("rnd%0d", k), 0, 6'd0, '0, n);
      end

      // Asynchronous reset during E of INCR r2
      do_reset();
      load(6'd0, enc(I_LTR, 3'd2, 3'd0, 32'd5));
      load(6'd1, enc(I_INCR, 3'd2, 3'd0, 32'd0));
      load(6'd2, enc(I_HLT, 3'd0, 3'd0, 32'd0));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("t5.halted", 32'(halted), 32'd1);
      chk("t5.pc0", 32'(pc), 32'd0);
      chk("t5.ret0", retired, 32'd0);
      chk_gpr("t5.r2zero", 2, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      run_and_check("t5b", 2, 6'd1, enc(I_HLT, 3'd0, 3'd0, 32'd0), n);
      chk_gpr("t5b.r2is6", 2, 32'd6);

      // pc wrap across the full command memory
      do_reset();
      for (int a = 0; a < 64; a++) load(6'(a), enc(I_INCR, 3'd1, 3'd0, 32'd0));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (315) @(posedge clk);
      #1;
      chk("t6.pc63", 32'(pc), 32'd63);
      chk("t6.ret63", retired, 32'd63);
      repeat (5) @(posedge clk);
      #1;
      chk("t6.pcwrap", 32'(pc), 32'd0);
      chk("t6.ret64", retired, 32'd64);
      chk("t6.running", 32'(halted), 32'd0);
      chk_gpr("t6.r1", 1, 32'd64);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
